// File: rtl/counter_up_down_multi.sv
// ---------------------------------------------------------------------------
// counter_up_down_multi
//
// Purpose
//   A bank of CHANNELS independent up/down counters, each WIDTH bits wide.
//   Each channel has its own clear, enable, load, direction and boundary-mode
//   controls. Every channel registers its count and a one-cycle terminal-count
//   pulse. A zero flag is decoded directly from the count register.
//
// Parameters
//   WIDTH     counter width per channel in bits (legal 2..32, default 8)
//   CHANNELS  number of independent channels   (legal 1..16, default 4)
//
// Configuration macro
//   COUNTER_SATURATE_EN
//     When defined, Sat_Mode[i]=1 makes channel i saturate at its boundaries.
//     When undefined, Sat_Mode is accepted but ignored, and every channel wraps.
//
// Ports
//   Clk       in   1               rising-edge clock for all state
//   Reset_n   in   1               asynchronous active-low reset; deassertion
//                                  is assumed to be synchronised upstream
//   Enable    in   CHANNELS        per-channel enable; gates load and count
//   Clear     in   CHANNELS        per-channel synchronous clear; not gated by Enable
//   Load      in   CHANNELS        per-channel load request
//   UpDown    in   CHANNELS        per-channel direction, 1 = up, 0 = down
//   Sat_Mode  in   CHANNELS        per-channel boundary mode, 1 = saturate, 0 = wrap
//   In_Data   in   CHANNELS*WIDTH  load values, channel i at [i*WIDTH +: WIDTH]
//   Out_Data  out  CHANNELS*WIDTH  registered counts, same packing as In_Data
//   Term_Cnt  out  CHANNELS        registered one-cycle pulse on a boundary step
//   Zero      out  CHANNELS        high while that channel's Out_Data is zero
// ---------------------------------------------------------------------------
module counter_up_down_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [CHANNELS-1:0]       Enable,
    input  logic [CHANNELS-1:0]       Clear,
    input  logic [CHANNELS-1:0]       Load,
    input  logic [CHANNELS-1:0]       UpDown,
    input  logic [CHANNELS-1:0]       Sat_Mode,
    input  logic [CHANNELS*WIDTH-1:0] In_Data,
    output logic [CHANNELS*WIDTH-1:0] Out_Data,
    output logic [CHANNELS-1:0]       Term_Cnt,
    output logic [CHANNELS-1:0]       Zero
);

    typedef logic [WIDTH-1:0] cnt_t;

    // Per-channel action, decoded once from the control inputs in priority
    // order. Keeping the priority in one place makes the datapath below a
    // plain case on the chosen action.
    typedef enum logic [2:0] {
        ACT_HOLD  = 3'd0,
        ACT_CLEAR = 3'd1,
        ACT_LOAD  = 3'd2,
        ACT_INC   = 3'd3,
        ACT_DEC   = 3'd4
    } action_e;

    localparam cnt_t CNT_ZERO = '0;
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam cnt_t CNT_MAX  = '1;

    // Effective saturation enables. Without the macro, saturation is not
    // built, so every channel sees wrap mode regardless of Sat_Mode.
    logic [CHANNELS-1:0] sat_eff;

`ifdef COUNTER_SATURATE_EN
    assign sat_eff = Sat_Mode;
`else
    assign sat_eff = '0;

    // Sat_Mode stays on the port list so both builds share one interface;
    // fold it into a deliberately unused net so it is visibly consumed.
    logic unused_sat_mode;
    assign unused_sat_mode = ^Sat_Mode;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch

        action_e act;
        cnt_t    cnt_q;
        cnt_t    cnt_d;
        logic    tc_q;
        logic    tc_d;
        logic    at_max;
        logic    at_zero;

        assign at_max  = (cnt_q == CNT_MAX);
        assign at_zero = (cnt_q == CNT_ZERO);

        // Clear wins over everything, including a deasserted Enable. Only
        // after that does Enable gate load and counting.
        always_comb begin
            act = ACT_HOLD;
            if (Clear[g]) begin
                act = ACT_CLEAR;
            end else if (Enable[g]) begin
                if (Load[g]) begin
                    act = ACT_LOAD;
                end else if (UpDown[g]) begin
                    act = ACT_INC;
                end else begin
                    act = ACT_DEC;
                end
            end
        end

        // NOTE: every output of this block gets a default before the case,
        // so a path that skips an assignment cannot infer a latch.
        always_comb begin
            cnt_d = cnt_q;
            tc_d  = 1'b0;
            unique case (act)
                ACT_CLEAR: cnt_d = CNT_ZERO;
                ACT_LOAD:  cnt_d = In_Data[g*WIDTH +: WIDTH];
                ACT_INC: begin
                    // Modulo arithmetic wraps MAX+1 to zero on its own;
                    // saturation only needs to suppress the step.
                    tc_d = at_max;
                    if (!(at_max && sat_eff[g])) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ACT_DEC: begin
                    tc_d = at_zero;
                    if (!(at_zero && sat_eff[g])) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                    tc_d  = 1'b0;
                end
            endcase
        end

        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, whatever order the blocks are evaluated in.
        // NOTE: these are control-visible registers, not a storage array, so
        // all of them are reset; the count must read as zero during reset.
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                cnt_q <= CNT_ZERO;
                tc_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                tc_q  <= tc_d;
            end
        end

        assign Out_Data[g*WIDTH +: WIDTH] = cnt_q;
        assign Term_Cnt[g]                = tc_q;
        // Decoded straight from the register: no extra flop, no added latency.
        assign Zero[g]                    = at_zero;

    end : g_ch

endmodule : counter_up_down_multi

// File: tb/tb_counter_up_down_multi.sv
// ---------------------------------------------------------------------------
// tb_counter_up_down_multi
//
// Drives a default instance (WIDTH=8, CHANNELS=4) and a narrow instance
// (WIDTH=4, CHANNELS=1) from one directed sequence followed by a random
// section. A behavioural model predicts each cycle's outputs. The prediction
// is queued when the stimulus is applied and popped for comparison one edge
// later. The behaviour follows COUNTER_SATURATE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_counter_up_down_multi;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int SW = 4;

`ifdef COUNTER_SATURATE_EN
    localparam bit SAT_BUILT = 1'b1;
`else
    localparam bit SAT_BUILT = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic [CH-1:0]   en, clr, ld, ud, sat;
    logic [CH*W-1:0] din;
    logic [CH*W-1:0] out;
    logic [CH-1:0]   tc, zero;

    logic [0:0]      s_en, s_clr, s_ld, s_ud, s_sat;
    logic [SW-1:0]   s_din;
    logic [SW-1:0]   s_out;
    logic [0:0]      s_tc, s_zero;

    counter_up_down_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
        .Clk      (clk),
        .Reset_n  (rst_n),
        .Enable   (en),
        .Clear    (clr),
        .Load     (ld),
        .UpDown   (ud),
        .Sat_Mode (sat),
        .In_Data  (din),
        .Out_Data (out),
        .Term_Cnt (tc),
        .Zero     (zero)
    );

    counter_up_down_multi #(.WIDTH(SW), .CHANNELS(1)) dut_small (
        .Clk      (clk),
        .Reset_n  (rst_n),
        .Enable   (s_en),
        .Clear    (s_clr),
        .Load     (s_ld),
        .UpDown   (s_ud),
        .Sat_Mode (s_sat),
        .In_Data  (s_din),
        .Out_Data (s_out),
        .Term_Cnt (s_tc),
        .Zero     (s_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string          tag;
        logic [31:0]    out;
        logic [CH-1:0]  tc;
        logic [CH-1:0]  zero;
        logic [SW-1:0]  s_out;
        logic           s_tc;
        logic           s_zero;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0]  m_cnt [CH];
    logic [CH-1:0] m_tc;
    logic [SW-1:0] ms_cnt;
    logic          ms_tc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Generic one-channel reference, written against explicit boundary
    // values rather than relying on modulo overflow.
    function automatic void model_step(input logic [31:0] cnt, input int w,
                                       input logic e, input logic c, input logic l,
                                       input logic u, input logic s,
                                       input logic [31:0] d,
                                       output logic [31:0] nxt, output logic t);
        logic [31:0] maxv;
        logic        sat_on;
        maxv   = (32'd1 << w) - 32'd1;
        sat_on = s & SAT_BUILT;
        nxt    = cnt;
        t      = 1'b0;
        if (c) begin
            nxt = 32'd0;
        end else if (e && l) begin
            nxt = d & maxv;
        end else if (e && u) begin
            if (cnt == maxv) begin
                t   = 1'b1;
                nxt = sat_on ? cnt : 32'd0;
            end else begin
                nxt = cnt + 32'd1;
            end
        end else if (e) begin
            if (cnt == 32'd0) begin
                t   = 1'b1;
                nxt = sat_on ? 32'd0 : maxv;
            end else begin
                nxt = cnt - 32'd1;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) m_cnt[i] = '0;
        m_tc   = '0;
        ms_cnt = '0;
        ms_tc  = 1'b0;
    endfunction

    function automatic void push_expected(input string tag);
        exp_t e;
        e.tag = tag;
        e.out = '0;
        for (int i = 0; i < CH; i++) begin
            e.out[i*W +: W] = m_cnt[i];
            e.zero[i]       = (m_cnt[i] == '0);
        end
        e.tc     = m_tc;
        e.s_out  = ms_cnt;
        e.s_tc   = ms_tc;
        e.s_zero = (ms_cnt == '0);
        sb.push_back(e);
    endfunction

    task automatic pop_and_compare();
        exp_t e;
        e = sb.pop_front();
        check({e.tag, " out"},    out,            e.out);
        check({e.tag, " tc"},     32'(tc),        32'(e.tc));
        check({e.tag, " zero"},   32'(zero),      32'(e.zero));
        check({e.tag, " s_out"},  32'(s_out),     32'(e.s_out));
        check({e.tag, " s_tc"},   32'(s_tc),      32'(e.s_tc));
        check({e.tag, " s_zero"}, 32'(s_zero),    32'(e.s_zero));
    endtask

    // Advance the model with the inputs now applied, queue its prediction,
    // then clock the DUT and compare just after the edge.
    task automatic tick(input string tag);
        logic [31:0] nv;
        logic        t;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < CH; i++) begin
                model_step(32'(m_cnt[i]), W, en[i], clr[i], ld[i], ud[i], sat[i],
                           32'(din[i*W +: W]), nv, t);
                m_cnt[i] = nv[W-1:0];
                m_tc[i]  = t;
            end
            model_step(32'(ms_cnt), SW, s_en[0], s_clr[0], s_ld[0], s_ud[0], s_sat[0],
                       32'(s_din), nv, t);
            ms_cnt = nv[SW-1:0];
            ms_tc  = t;
        end
        push_expected(tag);
        @(posedge clk);
        #1;
        pop_and_compare();
    endtask

    // Compare the current outputs with no clock edge in between (reset paths).
    task automatic check_now(input string tag);
        push_expected(tag);
        #1;
        pop_and_compare();
    endtask

    initial begin
        rst_n = 1'b0;
        en = '0; clr = '0; ld = '0; ud = '0; sat = '0; din = '0;
        s_en = '0; s_clr = '0; s_ld = '0; s_ud = '0; s_sat = '0; s_din = '0;
        model_reset();

        repeat (2) @(posedge clk);
        check_now("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Clear beats a simultaneous enabled load; a load without Enable holds.
        en = 4'b0001; clr = 4'b0001; ld = 4'b0001; din = 32'h0000_0033;
        tick("clr_over_ld");
        check("clr_over_ld ch0", 32'(out[7:0]), 32'h00);
        clr = '0; en = '0;
        tick("ld_no_en");
        check("ld_no_en ch0", 32'(out[7:0]), 32'h00);
        en = 4'b0001;
        tick("ld_en");
        check("ld_en ch0", 32'(out[7:0]), 32'h33);

        // Asynchronous reset mid-count with ch0 at 5A.
        ld = 4'b0001; din = 32'h0000_005A;
        tick("ld_5a");
        ld = '0; ud = 4'b0001;
        #3;
        rst_n = 1'b0;
        model_reset();
        check_now("rst_mid");
        check("rst_mid ch0", 32'(out[7:0]), 32'h00);
        check("rst_mid tc", 32'(tc), 32'h0);
        check("rst_mid zero", 32'(zero), 32'hF);
        tick("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        en = '0; ud = '0;

        // Ch1 wraps upward through FF.
        en = 4'b0010; ld = 4'b0010; din = 32'h0000_FE00;
        tick("ch1_ld_fe");
        ld = '0; ud = 4'b0010; sat = '0;
        tick("ch1_up1");
        check("ch1_up1 val", 32'(out[15:8]), 32'hFF);
        check("ch1_up1 tc",  32'(tc[1]), 32'h0);
        tick("ch1_up2");
        check("ch1_up2 val", 32'(out[15:8]), 32'h00);
        check("ch1_up2 tc",  32'(tc[1]), 32'h1);
        tick("ch1_up3");
        check("ch1_up3 val", 32'(out[15:8]), 32'h01);
        check("ch1_up3 tc",  32'(tc[1]), 32'h0);

        // Ch2 counts down from 01 in saturate mode.
        en = 4'b0100; ld = 4'b0100; ud = '0; din = 32'h0001_0000;
        tick("ch2_ld_01");
        ld = '0; sat = 4'b0100;
        tick("ch2_dn1");
        check("ch2_dn1 val", 32'(out[23:16]), 32'h00);
        check("ch2_dn1 tc",  32'(tc[2]), 32'h0);
        tick("ch2_dn2");
        check("ch2_dn2 val", 32'(out[23:16]), SAT_BUILT ? 32'h00 : 32'hFF);
        check("ch2_dn2 tc",  32'(tc[2]), 32'h1);
        tick("ch2_dn3");
        check("ch2_dn3 val", 32'(out[23:16]), SAT_BUILT ? 32'h00 : 32'hFE);
        check("ch2_dn3 tc",  32'(tc[2]), SAT_BUILT ? 32'h1 : 32'h0);

        // Ch3 counts up into FF in saturate mode, then UpDown flips mid-count.
        en = 4'b1000; ld = 4'b1000; ud = 4'b1000; sat = 4'b1000; din = 32'hFF00_0000;
        tick("ch3_ld_ff");
        ld = '0;
        tick("ch3_up1");
        tick("ch3_up2");
        ud = '0;
        tick("ch3_dn");
        en = '0; sat = '0;

        // Narrow build: 4-bit single channel wraps from F.
        s_en = 1'b1; s_ld = 1'b1; s_din = 4'hF;
        tick("small_ld_f");
        check("small_ld_f val", 32'(s_out), 32'hF);
        s_ld = 1'b0; s_ud = 1'b1;
        tick("small_up1");
        check("small_up1 val",  32'(s_out),  32'h0);
        check("small_up1 tc",   32'(s_tc),   32'h1);
        check("small_up1 zero", 32'(s_zero), 32'h1);
        tick("small_up2");
        check("small_up2 val", 32'(s_out), 32'h1);
        check("small_up2 tc",  32'(s_tc),  32'h0);

        // Concurrent random traffic on every channel of both instances.
        for (int n = 0; n < 1000; n++) begin
            en    = 4'($urandom);
            clr   = 4'($urandom) & 4'($urandom) & 4'($urandom);
            ld    = 4'($urandom) & 4'($urandom);
            ud    = 4'($urandom);
            sat   = 4'($urandom);
            din   = $urandom;
            s_en  = 1'($urandom);
            s_clr = 1'($urandom_range(0, 7) == 0);
            s_ld  = 1'($urandom_range(0, 3) == 0);
            s_ud  = 1'($urandom);
            s_sat = 1'($urandom);
            s_din = 4'($urandom);
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_counter_up_down_multi
